core_pc_redirect: RTL and testbench
===================================

CORE_PC_REDIRECT -- requirements
Module: core_pc_redirect

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the width of PC, ALU result and target buses.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ex_valid  in  1  execute-stage instruction valid.
REQ-005 SHALL have port ex_ready  out  1  block can accept the execute-stage instruction.
REQ-006 SHALL have port pc_src  in  core_pkg::pc_src_e  PC source: PC_NEXT, PC_JUMP or PC_BRANCH.
REQ-007 SHALL have port br_type  in  core_pkg::br_type_e  branch condition: BRANCH_Z or BRANCH_NZ.
REQ-008 SHALL have port alu_result  in  XLEN  jump target (PC_JUMP) or compare result (PC_BRANCH).
REQ-009 SHALL have port br_target  in  XLEN  branch target address.
REQ-010 SHALL have port trap_valid  in  1  trap or xRET redirect request from the trap unit.
REQ-011 SHALL have port trap_target  in  XLEN  trap or xRET target address.
REQ-012 SHALL have port redir_valid  out  1  redirect offered to fetch.
REQ-013 SHALL have port redir_pc  out  XLEN  redirect address.
REQ-014 SHALL have port redir_ready  in  1  fetch accepts the redirect.
REQ-015 SHALL have port flush  out  1  one-cycle pulse that kills younger instructions.
REQ-016 SHALL have port misalign_valid  out  1  one-cycle instruction-address-misaligned pulse.
REQ-017 SHALL have port misalign_addr  out  XLEN  the faulting target address.

Function
REQ-018 Taken decision SHALL be:
- PC_JUMP: always taken.
- PC_BRANCH: taken when (BRANCH_NZ and alu_result!=0) or (BRANCH_Z and alu_result==0).
- Any other pc_src: not taken.
REQ-019 Target SHALL be {alu_result[XLEN-1:1],1'b0} for PC_JUMP and br_target for PC_BRANCH.
REQ-020 The state machine SHALL have two states, IDLE and PENDING; redir_valid = (state==PENDING); ex_ready = (state==IDLE).
REQ-021 An accept occurs on ex_valid & ex_ready. An accept of a taken, aligned instruction SHALL go to PENDING at the next edge, latching redir_pc=target and pulsing flush for exactly that next cycle (latency 1).
REQ-022 While PENDING, redir_pc SHALL stay stable; redir_valid & redir_ready SHALL return the block to IDLE at the next edge.
REQ-023 An accepted not-taken instruction SHALL produce no state change and no pulses.
REQ-024 trap_valid SHALL have highest priority in any state. At the next edge: state=PENDING, redir_pc=trap_target, flush pulses.
- Any concurrent accept is discarded.
- Any concurrent misalignment is suppressed.
- Any concurrent redir handshake is overridden.
REQ-025 Misalignment (see REQ-030) on an accept SHALL consume the instruction, stay IDLE, and pulse misalign_valid for one cycle with misalign_addr=target.

Reset
REQ-026 rst SHALL asynchronously force state=IDLE, redir_pc=0, flush=0, misalign_valid=0, misalign_addr=0; hence redir_valid=0 and ex_ready=1.
REQ-027 rst asserted while PENDING SHALL drop the pending redirect without a handshake.
REQ-028 flush and misalign pulses SHALL NOT be issued in the first cycle after rst deasserts.

Configuration
REQ-029 With macro CORE_RVC_EN defined, targets SHALL only need 2-byte alignment, so misalign_valid is never asserted.
REQ-030 Without CORE_RVC_EN, a taken target with bit[1]=1 SHALL be treated as misaligned per REQ-025.

Structure
REQ-031 pc_src_e and br_type_e SHALL remain in core_pkg; the redir_state_e enum (IDLE, PENDING) SHALL be added to core_pkg.
REQ-032 The taken/target/misalign decision SHALL be one combinational sub-module, core_br_decide. All state SHALL live in core_pc_redirect.

Verification
REQ-033 JUMP, alu_result=0x0000_1235, redir_ready=1 -> next cycle redir_valid=1, redir_pc=0x0000_1234, flush=1; IDLE one cycle later.
REQ-034 BRANCH BRANCH_Z, alu_result=0 (taken) vs 5 (not taken), br_target=0x200 -> redirect to 0x200 only for the zero case.
REQ-035 Taken branch to 0x300 with redir_ready=0 for 3 cycles -> redir_valid and redir_pc=0x300 held, ex_ready=0, flush exactly one cycle.
REQ-036 trap_valid with trap_target=0x8000_0000 while PENDING to 0x300 -> redir_pc=0x8000_0000, second flush pulse.
REQ-037 Without CORE_RVC_EN, BRANCH target 0x0000_0102 -> misalign_valid=1 for one cycle, misalign_addr=0x102, no redirect; with CORE_RVC_EN -> redirect to 0x102.
REQ-038 rst asserted mid-PENDING -> redir_valid=0 immediately; ex_ready=1 after release.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: PC source, branch condition and redirect FSM state.
// Also carries the branch-condition helper used by core_br_decide.
package core_pkg;

   typedef enum logic [1:0] {
      PC_NEXT   = 2'd0,
      PC_JUMP   = 2'd1,
      PC_BRANCH = 2'd2
   } pc_src_e;

   typedef enum logic {
      BRANCH_Z  = 1'b0,
      BRANCH_NZ = 1'b1
   } br_type_e;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } redir_state_e;

   // alu_result carries the compare outcome; only zero/non-zero matters.
   function automatic logic br_cond(input br_type_e br_type, input logic is_zero);
      logic taken;
      unique case (br_type)
         BRANCH_Z:  taken = is_zero;
         BRANCH_NZ: taken = !is_zero;
         default:   taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/core_br_decide.sv
// Combinational taken/target/misalign decision for execute-stage control flow.
// Macro CORE_RVC_EN relaxes alignment to 2 bytes, so misalign_o is never raised.
module core_br_decide
   import core_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  pc_src_e         pc_src_i,
   input  br_type_e        br_type_i,
   input  logic [XLEN-1:0] alu_result_i,
   input  logic [XLEN-1:0] br_target_i,
   output logic            taken_o,
   output logic [XLEN-1:0] target_o,
   output logic            misalign_o
);

   logic alu_zero;
   assign alu_zero = (alu_result_i == '0);

   always_comb begin
      taken_o  = 1'b0;
      target_o = br_target_i;
      case (pc_src_i)
         PC_JUMP: begin
            taken_o  = 1'b1;
            target_o = {alu_result_i[XLEN-1:1], 1'b0};
         end
         PC_BRANCH: begin
            taken_o  = br_cond(br_type_i, alu_zero);
            target_o = br_target_i;
         end
         default: begin
            taken_o  = 1'b0;
            target_o = br_target_i;
         end
      endcase
   end

`ifdef CORE_RVC_EN
   assign misalign_o = 1'b0;
`else
   assign misalign_o = taken_o & target_o[1];
`endif

endmodule

// File: rtl/core_pc_redirect.sv
// PC redirect block: turns taken jumps/branches and traps into a held fetch redirect
// plus one-cycle flush / misalign pulses. Macro CORE_RVC_EN (see core_br_decide).
module core_pc_redirect
   import core_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  pc_src_e         pc_src,
   input  br_type_e        br_type,
   input  logic [XLEN-1:0] alu_result,
   input  logic [XLEN-1:0] br_target,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_target,
   output logic            redir_valid,
   output logic [XLEN-1:0] redir_pc,
   input  logic            redir_ready,
   output logic            flush,
   output logic            misalign_valid,
   output logic [XLEN-1:0] misalign_addr
);

   redir_state_e    state_q;
   logic [XLEN-1:0] redir_pc_q;
   logic            flush_q;
   logic            misalign_valid_q;
   logic [XLEN-1:0] misalign_addr_q;

   logic            taken;
   logic [XLEN-1:0] target;
   logic            misalign;
   logic            accept;

   core_br_decide #(
      .XLEN (XLEN)
   ) u_br_decide (
      .pc_src_i     (pc_src),
      .br_type_i    (br_type),
      .alu_result_i (alu_result),
      .br_target_i  (br_target),
      .taken_o      (taken),
      .target_o     (target),
      .misalign_o   (misalign)
   );

   assign accept = ex_valid & (state_q == IDLE);

   // Pulses default low each cycle; trap overrides accept, misalign and handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         redir_pc_q       <= '0;
         flush_q          <= 1'b0;
         misalign_valid_q <= 1'b0;
         misalign_addr_q  <= '0;
      end else begin
         flush_q          <= 1'b0;
         misalign_valid_q <= 1'b0;
         if (trap_valid) begin
            state_q    <= PENDING;
            redir_pc_q <= trap_target;
            flush_q    <= 1'b1;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (accept && taken) begin
                     if (misalign) begin
                        misalign_valid_q <= 1'b1;
                        misalign_addr_q  <= target;
                     end else begin
                        state_q    <= PENDING;
                        redir_pc_q <= target;
                        flush_q    <= 1'b1;
                     end
                  end
               end
               PENDING: begin
                  if (redir_ready) begin
                     state_q <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign ex_ready       = (state_q == IDLE);
   assign redir_valid    = (state_q == PENDING);
   assign redir_pc       = redir_pc_q;
   assign flush          = flush_q;
   assign misalign_valid = misalign_valid_q;
   assign misalign_addr  = misalign_addr_q;

endmodule

// File: tb/tb_core_pc_redirect.sv
// Directed bench for core_pc_redirect: inputs change on negedge, outputs sampled on negedge.
// Honors CORE_RVC_EN to pick the expected misalignment behaviour.
module tb_core_pc_redirect;
   import core_pkg::*;

   localparam int unsigned XLEN = 32;

   logic            clk;
   logic            rst;
   logic            ex_valid;
   logic            ex_ready;
   pc_src_e         pc_src;
   br_type_e        br_type;
   logic [XLEN-1:0] alu_result;
   logic [XLEN-1:0] br_target;
   logic            trap_valid;
   logic [XLEN-1:0] trap_target;
   logic            redir_valid;
   logic [XLEN-1:0] redir_pc;
   logic            redir_ready;
   logic            flush;
   logic            misalign_valid;
   logic [XLEN-1:0] misalign_addr;

   int n_tests;
   int n_fail;

   core_pc_redirect #(
      .XLEN (XLEN)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ex_valid       (ex_valid),
      .ex_ready       (ex_ready),
      .pc_src         (pc_src),
      .br_type        (br_type),
      .alu_result     (alu_result),
      .br_target      (br_target),
      .trap_valid     (trap_valid),
      .trap_target    (trap_target),
      .redir_valid    (redir_valid),
      .redir_pc       (redir_pc),
      .redir_ready    (redir_ready),
      .flush          (flush),
      .misalign_valid (misalign_valid),
      .misalign_addr  (misalign_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      ex_valid    = 1'b0;
      pc_src      = PC_NEXT;
      br_type     = BRANCH_Z;
      alu_result  = '0;
      br_target   = '0;
      trap_valid  = 1'b0;
      trap_target = '0;
   endtask

   task automatic test_reset();
      n_tests++;
      if (redir_valid !== 1'b0 || ex_ready !== 1'b1 || redir_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b ready=%b pc=%h, want 0 1 0",
                  redir_valid, ex_ready, redir_pc);
      end
      n_tests++;
      if (flush !== 1'b0 || misalign_valid !== 1'b0 || misalign_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_pulses: flush=%b mis=%b addr=%h, want 0 0 0",
                  flush, misalign_valid, misalign_addr);
      end
      @(negedge clk);
      rst = 1'b0;
      // First cycle out of reset: nothing may pulse.
      @(negedge clk);
      n_tests++;
      if (flush !== 1'b0 || misalign_valid !== 1'b0 || ex_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset: flush=%b mis=%b ready=%b, want 0 0 1",
                  flush, misalign_valid, ex_ready);
      end
   endtask

   task automatic test_jump();
      redir_ready = 1'b1;
      ex_valid    = 1'b1;
      pc_src      = PC_JUMP;
      alu_result  = 32'h0000_1235;
      @(negedge clk);
      idle_inputs();
      n_tests++;
      if (redir_valid !== 1'b1 || redir_pc !== 32'h0000_1234 || flush !== 1'b1) begin
         n_fail++;
         $display("FAIL jump_redirect: valid=%b pc=%h flush=%b, want 1 00001234 1",
                  redir_valid, redir_pc, flush);
      end
      @(negedge clk);
      n_tests++;
      if (redir_valid !== 1'b0 || ex_ready !== 1'b1 || flush !== 1'b0) begin
         n_fail++;
         $display("FAIL jump_return: valid=%b ready=%b flush=%b, want 0 1 0",
                  redir_valid, ex_ready, flush);
      end
   endtask

   task automatic test_branch_z();
      redir_ready = 1'b1;
      ex_valid    = 1'b1;
      pc_src      = PC_BRANCH;
      br_type     = BRANCH_Z;
      br_target   = 32'h0000_0200;
      alu_result  = 32'd5;
      @(negedge clk);
      n_tests++;
      if (redir_valid !== 1'b0 || flush !== 1'b0 || misalign_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL branch_z_not_taken: valid=%b flush=%b mis=%b, want 0 0 0",
                  redir_valid, flush, misalign_valid);
      end
      alu_result = 32'd0;
      @(negedge clk);
      idle_inputs();
      n_tests++;
      if (redir_valid !== 1'b1 || redir_pc !== 32'h0000_0200 || flush !== 1'b1) begin
         n_fail++;
         $display("FAIL branch_z_taken: valid=%b pc=%h flush=%b, want 1 00000200 1",
                  redir_valid, redir_pc, flush);
      end
      @(negedge clk);
   endtask

   task automatic test_not_taken();
      ex_valid   = 1'b1;
      pc_src     = PC_NEXT;
      alu_result = 32'h0000_4000;
      br_target  = 32'h0000_5000;
      @(negedge clk);
      br_type    = BRANCH_NZ;
      pc_src     = PC_BRANCH;
      alu_result = 32'd0;
      n_tests++;
      if (redir_valid !== 1'b0 || flush !== 1'b0 || redir_pc !== 32'h0000_0200) begin
         n_fail++;
         $display("FAIL pc_next: valid=%b flush=%b pc=%h, want 0 0 00000200",
                  redir_valid, flush, redir_pc);
      end
      @(negedge clk);
      idle_inputs();
      n_tests++;
      if (redir_valid !== 1'b0 || flush !== 1'b0 || ex_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL branch_nz_not_taken: valid=%b flush=%b ready=%b, want 0 0 1",
                  redir_valid, flush, ex_ready);
      end
   endtask

   task automatic test_stall_and_trap();
      int flush_cnt;
      flush_cnt   = 0;
      redir_ready = 1'b0;
      ex_valid    = 1'b1;
      pc_src      = PC_BRANCH;
      br_type     = BRANCH_NZ;
      alu_result  = 32'd1;
      br_target   = 32'h0000_0300;
      @(negedge clk);
      // Keep offering a different taken branch; it must not be accepted.
      br_target = 32'h0000_0400;
      for (int i = 0; i < 3; i++) begin
         if (flush === 1'b1) flush_cnt++;
         n_tests++;
         if (redir_valid !== 1'b1 || redir_pc !== 32'h0000_0300 || ex_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: valid=%b pc=%h ready=%b, want 1 00000300 0",
                     i, redir_valid, redir_pc, ex_ready);
         end
         @(negedge clk);
      end
      n_tests++;
      if (flush_cnt != 1) begin
         n_fail++;
         $display("FAIL stall_flush_count: got %0d, want 1", flush_cnt);
      end
      // Trap while pending also overrides a concurrent handshake.
      idle_inputs();
      trap_valid  = 1'b1;
      trap_target = 32'h8000_0000;
      redir_ready = 1'b1;
      @(negedge clk);
      trap_valid = 1'b0;
      n_tests++;
      if (redir_valid !== 1'b1 || redir_pc !== 32'h8000_0000 || flush !== 1'b1) begin
         n_fail++;
         $display("FAIL trap_redirect: valid=%b pc=%h flush=%b, want 1 80000000 1",
                  redir_valid, redir_pc, flush);
      end
      @(negedge clk);
      n_tests++;
      if (redir_valid !== 1'b0 || ex_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL trap_return: valid=%b ready=%b, want 0 1", redir_valid, ex_ready);
      end
   endtask

   task automatic test_misalign();
      redir_ready = 1'b1;
      ex_valid    = 1'b1;
      pc_src      = PC_BRANCH;
      br_type     = BRANCH_NZ;
      alu_result  = 32'd7;
      br_target   = 32'h0000_0102;
      @(negedge clk);
      idle_inputs();
`ifdef CORE_RVC_EN
      n_tests++;
      if (redir_valid !== 1'b1 || redir_pc !== 32'h0000_0102 || misalign_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rvc_redirect: valid=%b pc=%h mis=%b, want 1 00000102 0",
                  redir_valid, redir_pc, misalign_valid);
      end
`else
      n_tests++;
      if (misalign_valid !== 1'b1 || misalign_addr !== 32'h0000_0102 ||
          redir_valid !== 1'b0 || flush !== 1'b0) begin
         n_fail++;
         $display("FAIL misalign_pulse: mis=%b addr=%h valid=%b flush=%b, want 1 00000102 0 0",
                  misalign_valid, misalign_addr, redir_valid, flush);
      end
`endif
      @(negedge clk);
      n_tests++;
      if (misalign_valid !== 1'b0 || ex_ready !== 1'b1 || redir_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL misalign_after: mis=%b ready=%b valid=%b, want 0 1 0",
                  misalign_valid, ex_ready, redir_valid);
      end
      // Trap suppresses a concurrent misaligned accept.
      ex_valid    = 1'b1;
      pc_src      = PC_BRANCH;
      br_type     = BRANCH_NZ;
      alu_result  = 32'd7;
      br_target   = 32'h0000_0106;
      trap_valid  = 1'b1;
      trap_target = 32'h0000_0800;
      @(negedge clk);
      idle_inputs();
      n_tests++;
      if (misalign_valid !== 1'b0 || redir_pc !== 32'h0000_0800 || redir_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL trap_vs_misalign: mis=%b pc=%h valid=%b, want 0 00000800 1",
                  misalign_valid, redir_pc, redir_valid);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      redir_ready = 1'b1;
      ex_valid    = 1'b1;
      pc_src      = PC_JUMP;
      alu_result  = 32'h0000_0A01;
      @(negedge clk);
      ex_valid = 1'b0;
      @(negedge clk);
      ex_valid   = 1'b1;
      alu_result = 32'h0000_0B10;
      @(negedge clk);
      idle_inputs();
      n_tests++;
      if (redir_valid !== 1'b1 || redir_pc !== 32'h0000_0B10 || flush !== 1'b1) begin
         n_fail++;
         $display("FAIL back_to_back: valid=%b pc=%h flush=%b, want 1 00000b10 1",
                  redir_valid, redir_pc, flush);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_pending();
      redir_ready = 1'b0;
      ex_valid    = 1'b1;
      pc_src      = PC_JUMP;
      alu_result  = 32'h0000_0C00;
      @(negedge clk);
      idle_inputs();
      n_tests++;
      if (redir_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_setup: valid=%b, want 1", redir_valid);
      end
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (redir_valid !== 1'b0 || ex_ready !== 1'b1 || redir_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_async: valid=%b ready=%b pc=%h, want 0 1 0",
                  redir_valid, ex_ready, redir_pc);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (redir_valid !== 1'b0 || ex_ready !== 1'b1 || flush !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_release: valid=%b ready=%b flush=%b, want 0 1 0",
                  redir_valid, ex_ready, flush);
      end
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      rst         = 1'b1;
      redir_ready = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      test_reset();
      test_jump();
      test_branch_z();
      test_not_taken();
      test_stall_and_trap();
      test_misalign();
      test_back_to_back();
      test_reset_pending();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
